// File: rtl/team_06_button_cond.sv
// -----------------------------------------------------------------------------
// team_06_button_cond
//
// Input conditioner for the four team_06 walkie-talkie user buttons
// (push-to-talk, effect-cycle, mute, noise-gate). Each raw pad is
// asynchronous and bouncing. This block synchronises it with two flops,
// normalises its polarity so that 1 = pressed, and debounces it with a
// per-channel stability counter. It then provides:
//   * clean registered levels for the control FSM, which detects edges itself;
//   * registered single-cycle rising-edge pulses for other consumers
//     such as the LCD/status logic.
//
// Parameters
//   CNT_W           width of each per-channel debounce counter
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a change
//                   (1 .. 2^CNT_W-1; 1 leaves only the synchroniser path)
//   ACTIVE_LOW      1 = pads read 0 when pressed, 0 = pads read 1 when pressed
//
// Ports
//   clk, rst                    system clock, asynchronous active-high reset
//   btn_*_raw                   raw pad inputs (ptt, effect, mute, ng)
//   ptt_en/effect/mute/ng_en    debounced levels (1 = pressed)
//   *_rise                      1-cycle pulse when the matching level goes 0->1
//   any_press                   OR of the four rise pulses
//
// Timing: a raw change first sampled at edge E reaches the level output
// after edge E+1+DEBOUNCE_CYCLES. Presses and releases have the same latency.
// -----------------------------------------------------------------------------
module team_06_button_cond #(
    parameter int               CNT_W           = 16,
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic             ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_ptt_raw,
    input  logic btn_effect_raw,
    input  logic btn_mute_raw,
    input  logic btn_ng_raw,
    output logic ptt_en,
    output logic effect,
    output logic mute,
    output logic ng_en,
    output logic ptt_rise,
    output logic effect_rise,
    output logic mute_rise,
    output logic ng_rise,
    output logic any_press
);

    localparam int NCH = 4;

    // The counter stops at this value. Reaching it while the sample still
    // differs from the level accepts the change, so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = DEBOUNCE_CYCLES - 1'b1;

    // The synchroniser resets to the pad's idle value. A pad that is
    // released at reset then cannot look like a press.
    localparam logic [NCH-1:0] RELEASED = {NCH{ACTIVE_LOW}};

    // Channel order: 0 = ptt, 1 = effect, 2 = mute, 3 = noise gate.
    logic [NCH-1:0] raw_vec;
    logic [NCH-1:0] s1_reg;
    logic [NCH-1:0] s2_reg;
    logic [NCH-1:0] lvl_vec;
    logic [NCH-1:0] rise_vec;

    assign raw_vec = {btn_ng_raw, btn_mute_raw, btn_effect_raw, btn_ptt_raw};

    // -------------------------------------------------------------------------
    // Two-flop synchroniser, all channels together
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg <= RELEASED;
            s2_reg <= RELEASED;
        end else begin
            s1_reg <= raw_vec;
            s2_reg <= s1_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel debounce and rise-pulse generation
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic             n_sample;
            logic             lvl_reg;
            logic             lvl_next;
            logic             rise_reg;
            logic             rise_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            // Normalised synchronised sample: 1 means pressed.
            assign n_sample = s2_reg[gi] ^ ACTIVE_LOW;

            // The count measures how long the sample has disagreed with
            // the accepted level without a break. One agreeing cycle
            // restarts it. A change is accepted on the DEBOUNCE_CYCLES-th
            // consecutive disagreeing cycle. The rise pulse is registered
            // together with the level, so it is high in exactly the first
            // cycle that the level reads 1.
            always_comb begin
                lvl_next  = lvl_reg;
                cnt_next  = cnt_reg;
                rise_next = 1'b0;
                if (n_sample == lvl_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    lvl_next  = n_sample;
                    cnt_next  = '0;
                    rise_next = n_sample;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lvl_reg  <= 1'b0;
                    cnt_reg  <= '0;
                    rise_reg <= 1'b0;
                end else begin
                    lvl_reg  <= lvl_next;
                    cnt_reg  <= cnt_next;
                    rise_reg <= rise_next;
                end
            end

            assign lvl_vec[gi]  = lvl_reg;
            assign rise_vec[gi] = rise_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign ptt_en      = lvl_vec[0];
    assign effect      = lvl_vec[1];
    assign mute        = lvl_vec[2];
    assign ng_en       = lvl_vec[3];

    assign ptt_rise    = rise_vec[0];
    assign effect_rise = rise_vec[1];
    assign mute_rise   = rise_vec[2];
    assign ng_rise     = rise_vec[3];

    // This is combinational on registered pulses, so it is glitch-free
    // within the cycle. It is not an extra register stage.
    assign any_press   = |rise_vec;

endmodule
